// File: rtl/commit_trace_collector_if.sv
// Writeback-record and trace-sink signal bundle for commit_trace_collector.
// master: writeback stage / trace sink side; slave: the collector itself.
interface commit_trace_collector_if;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic [63:0] wb_dnpc;
    logic        wb_kill;
    logic        wb_invalid;
    logic        wb_ebreak;
    logic        wb_stall;
    logic        trace_hold;
    logic [31:0] out_inst;
    logic [63:0] out_dnpc;
    logic        out_kill;
    logic        out_invalid;
    logic        out_en;

    modport master (
        output wb_valid, wb_inst, wb_dnpc, wb_kill, wb_invalid, wb_ebreak, trace_hold,
        input  wb_stall, out_inst, out_dnpc, out_kill, out_invalid, out_en
    );

    modport slave (
        input  wb_valid, wb_inst, wb_dnpc, wb_kill, wb_invalid, wb_ebreak, trace_hold,
        output wb_stall, out_inst, out_dnpc, out_kill, out_invalid, out_en
    );
endinterface

// File: rtl/commit_trace_collector.sv
// Commit trace collector: buffers one retired-instruction record per cycle in a
// small FIFO, streams it as a registered one-record-per-cycle trace, and
// sequences end of simulation (drain on ebreak/invalid, then halt).
// Optional watchdog built only when COMMIT_WATCHDOG_EN is defined.
module commit_trace_collector #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    commit_trace_collector_if.slave  bus,
    output logic                     halt,
    output logic                     halt_invalid,
    output logic [63:0]              retire_cnt,
    output logic                     wdog_expired
);
    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WDOG_CYCLES == 0) begin : g_bad_param
        $error("commit_trace_collector: DEPTH must be a power of two >= 2 and WDOG_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] dnpc;
        logic        kill;
        logic        invalid;
    } rec_t;

    state_e        state_q, state_d;
    rec_t          mem_q [DEPTH];
    rec_t          mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   out_inst_q, out_inst_d;
    logic [63:0]   out_dnpc_q, out_dnpc_d;
    logic          out_kill_q, out_kill_d;
    logic          out_inv_q, out_inv_d;
    logic          out_en_q, out_en_d;
    logic          halt_q, halt_d;
    logic          halt_inv_q, halt_inv_d;
    logic [63:0]   retire_q, retire_d;

    logic          full, empty, stall, push, pop, wdog_fire;
    rec_t          head_rec;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    // Stall depends only on registered state, never on trace_hold.
    assign stall    = (state_q != RUN) | full;
    assign push     = bus.wb_valid & ~stall;
    assign pop      = (state_q == RUN || state_q == DRAIN) & ~empty & ~bus.trace_hold;
    assign head_rec = mem_q[head_q];

`ifdef COMMIT_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_exp_q, wdog_exp_d;

    // Watchdog: counts RUN cycles since the last retiring push.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        wdog_exp_d = wdog_exp_q;
        wdog_fire  = 1'b0;
        if (state_q == RUN) begin
            if (push && !bus.wb_kill) begin
                wdog_cnt_d = '0;
            end else if (wdog_cnt_q == WW'(WDOG_CYCLES - 1)) begin
                wdog_fire  = 1'b1;
                wdog_exp_d = 1'b1;
                wdog_cnt_d = wdog_cnt_q + 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_exp_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_exp_q <= wdog_exp_d;
        end
    end

    assign wdog_expired = wdog_exp_q;
`else
    assign wdog_fire    = 1'b0;
    assign wdog_expired = 1'b0;
`endif

    // FIFO storage write at the tail.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = '{inst: bus.wb_inst, dnpc: bus.wb_dnpc,
                              kill: bus.wb_kill, invalid: bus.wb_invalid};
        end
    end

    // FIFO storage register; contents need no reset, pointers gate validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Next-state, pointer, output-record and retire-count logic.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        out_inst_d = out_inst_q;
        out_dnpc_d = out_dnpc_q;
        out_kill_d = 1'b0;
        out_inv_d  = 1'b0;
        out_en_d   = 1'b0;
        halt_d     = halt_q | (state_q == HALTED);
        halt_inv_d = halt_inv_q;
        retire_d   = retire_q;

        if (push) begin
            tail_d = tail_q + 1'b1;
        end

        if (pop) begin
            head_d     = head_q + 1'b1;
            out_inst_d = head_rec.inst;
            out_dnpc_d = head_rec.dnpc;
            out_kill_d = head_rec.kill;
            out_inv_d  = head_rec.invalid;
            out_en_d   = 1'b1;
            if (!head_rec.kill) begin
                retire_d = retire_q + 64'd1;
            end
        end

        case (state_q)
            RUN: begin
                if (wdog_fire) begin
                    state_d    = DRAIN;
                    halt_inv_d = 1'b0;
                end else if (push && !bus.wb_kill && (bus.wb_ebreak || bus.wb_invalid)) begin
                    state_d    = DRAIN;
                    halt_inv_d = bus.wb_invalid;
                end
            end
            DRAIN: begin
                // An empty FIFO here only happens after a watchdog trip.
                if (empty || (pop && count_q == (AW + 1)'(1))) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            out_inst_q <= '0;
            out_dnpc_q <= '0;
            out_kill_q <= 1'b0;
            out_inv_q  <= 1'b0;
            out_en_q   <= 1'b0;
            halt_q     <= 1'b0;
            halt_inv_q <= 1'b0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            out_inst_q <= out_inst_d;
            out_dnpc_q <= out_dnpc_d;
            out_kill_q <= out_kill_d;
            out_inv_q  <= out_inv_d;
            out_en_q   <= out_en_d;
            halt_q     <= halt_d;
            halt_inv_q <= halt_inv_d;
            retire_q   <= retire_d;
        end
    end

    assign bus.wb_stall    = stall;
    assign bus.out_inst    = out_inst_q;
    assign bus.out_dnpc    = out_dnpc_q;
    assign bus.out_kill    = out_kill_q;
    assign bus.out_invalid = out_inv_q;
    assign bus.out_en      = out_en_q;
    assign halt            = halt_q;
    assign halt_invalid    = halt_inv_q;
    assign retire_cnt      = retire_q;
endmodule

// File: tb/tb_commit_trace_collector.sv
// Self-checking bench for commit_trace_collector: expected records are queued
// as stimulus is driven and compared against records the DUT emits.
module tb_commit_trace_collector;
    localparam int unsigned DEPTH = 4;
`ifdef COMMIT_WATCHDOG_EN
    localparam int unsigned WDOG = 16;
`else
    localparam int unsigned WDOG = 4096;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] dnpc;
        logic        kill;
        logic        invalid;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt;
    logic        halt_invalid;
    logic [63:0] retire_cnt;
    logic        wdog_expired;

    commit_trace_collector_if bus ();

    commit_trace_collector #(.DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .halt         (halt),
        .halt_invalid (halt_invalid),
        .retire_cnt   (retire_cnt),
        .wdog_expired (wdog_expired)
    );

    always #5 clk = ~clk;

    rec_t        exp_q [$];
    rec_t        obs_q [$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_retire;
    logic [15:0] en_hist;

    // One clock; sample 1 time unit after the edge and collect emitted records.
    task automatic tick();
        rec_t r;
        @(posedge clk);
        #1;
        en_hist = {en_hist[14:0], bus.out_en};
        if (bus.out_en === 1'b1) begin
            r.inst    = bus.out_inst;
            r.dnpc    = bus.out_dnpc;
            r.kill    = bus.out_kill;
            r.invalid = bus.out_invalid;
            obs_q.push_back(r);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] dnpc,
                         input logic kill, input logic inv, input logic ebr);
        bus.wb_valid   = v;
        bus.wb_inst    = inst;
        bus.wb_dnpc    = dnpc;
        bus.wb_kill    = kill;
        bus.wb_invalid = inv;
        bus.wb_ebreak  = ebr;
    endtask

    // Drive a record expected to be accepted and queue its expected trace.
    task automatic push_exp(input logic [31:0] inst, input logic [63:0] dnpc,
                            input logic kill, input logic inv, input logic ebr);
        rec_t r;
        drive(1'b1, inst, dnpc, kill, inv, ebr);
        r.inst    = inst;
        r.dnpc    = dnpc;
        r.kill    = kill;
        r.invalid = inv;
        exp_q.push_back(r);
        if (!kill) exp_retire = exp_retire + 64'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.trace_hold = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        exp_retire = '0;
        en_hist    = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.wb_stall); end
        checks++; if (bus.out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en: got %b expected 0", bus.out_en); end
        checks++; if ({bus.out_kill, bus.out_invalid} !== 2'b00) begin errors++; $display("FAIL reset_out_flags: got %b expected 00", {bus.out_kill, bus.out_invalid}); end
        checks++; if ({bus.out_inst, bus.out_dnpc} !== 96'd0) begin errors++; $display("FAIL reset_out_rec: got %h expected 0", {bus.out_inst, bus.out_dnpc}); end
        checks++; if ({halt, halt_invalid, wdog_expired} !== 3'b000) begin errors++; $display("FAIL reset_halt: got %b expected 000", {halt, halt_invalid, wdog_expired}); end
        checks++; if (retire_cnt !== 64'd0) begin errors++; $display("FAIL reset_retire: got %0d expected 0", retire_cnt); end
    endtask

    task automatic test_basic();
        rec_t o, e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_exp(32'h0000_0013, 64'h8000_0004 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (en_hist[4:0] !== 5'b01110) begin errors++; $display("FAIL basic_en_timing: got %b expected 01110", en_hist[4:0]); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra: got %h expected none", o); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL basic_rec: got %h expected %h", o, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing: got %0d unemitted expected 0", exp_q.size()); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL basic_retire: got %0d expected %0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_back_to_back();
        rec_t o, e;
        do_reset();
        bus.trace_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp(32'h0010_0093 + 32'(i), 64'h8000_1000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
            tick();
            checks++; if (bus.wb_stall !== (i == 3)) begin errors++; $display("FAIL b2b_stall_%0d: got %b expected %b", i, bus.wb_stall, (i == 3)); end
        end
        // Full FIFO: this record must be refused although a pop happens now.
        drive(1'b1, 32'hDEAD_BEEF, 64'h8000_DEAD, 1'b0, 1'b0, 1'b0);
        bus.trace_hold = 1'b0;
        tick();
        checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_release: got %b expected 0", bus.wb_stall); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (en_hist[4:0] !== 5'b11110) begin errors++; $display("FAIL b2b_en_timing: got %b expected 11110", en_hist[4:0]); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra: got %h expected none", o); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_rec: got %h expected %h", o, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d unemitted expected 0", exp_q.size()); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL b2b_retire: got %0d expected %0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_kill_ebreak();
        rec_t o, e;
        do_reset();
        push_exp(32'h0010_0073, 64'h8000_0100, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.wb_stall !== 1'b0) begin errors++; $display("FAIL kill_no_drain: got stall %b expected 0", bus.wb_stall); end
        push_exp(32'h0000_0013, 64'h8000_0104, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL kill_halt: got %b expected 0", halt); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL kill_extra: got %h expected none", o); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL kill_rec: got %h expected %h", o, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL kill_missing: got %0d unemitted expected 0", exp_q.size()); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL kill_retire: got %0d expected %0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_drain_ebreak();
        rec_t o, e;
        do_reset();
        bus.trace_hold = 1'b1;
        push_exp(32'h0000_0013, 64'h8000_0204, 1'b0, 1'b0, 1'b0);
        tick();
        push_exp(32'h0000_0013, 64'h8000_0208, 1'b0, 1'b0, 1'b0);
        tick();
        push_exp(32'h0010_0073, 64'h8000_020C, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("FAIL drain_stall: got %b expected 1", bus.wb_stall); end
        // Offered while draining: must not be accepted.
        drive(1'b1, 32'h0000_0033, 64'h8000_0210, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL drain_early_halt: got %b expected 0", halt); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL drain_hold_leak: got %0d records expected 0", obs_q.size()); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.trace_hold = 1'b0;
        en_hist = '0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL drain_halt_same_cycle: got %b expected 0", halt); end
        tick();
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL drain_halt: got %b expected 1", halt); end
        checks++; if (en_hist[3:0] !== 4'b1110) begin errors++; $display("FAIL drain_en_timing: got %b expected 1110", en_hist[3:0]); end
        checks++; if (halt_invalid !== 1'b0) begin errors++; $display("FAIL drain_halt_invalid: got %b expected 0", halt_invalid); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL drain_extra: got %h expected none", o); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL drain_rec: got %h expected %h", o, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_missing: got %0d unemitted expected 0", exp_q.size()); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL drain_retire: got %0d expected %0d", retire_cnt, exp_retire); end
        drive(1'b1, 32'h0000_0013, 64'h8000_0300, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checks++; if (en_hist[2:0] !== 3'b000) begin errors++; $display("FAIL halted_out_en: got %b expected 000", en_hist[2:0]); end
        checks++; if ({bus.wb_stall, halt} !== 2'b11) begin errors++; $display("FAIL halted_sticky: got %b expected 11", {bus.wb_stall, halt}); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        obs_q.delete();
    endtask

    task automatic test_invalid();
        rec_t o, e;
        do_reset();
        push_exp(32'hFFFF_FFFF, 64'h8000_0400, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if ({halt, halt_invalid} !== 2'b11) begin errors++; $display("FAIL inv_halt: got %b expected 11", {halt, halt_invalid}); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL inv_extra: got %h expected none", o); end
            else begin
                e = exp_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL inv_rec: got %h expected %h", o, e); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL inv_missing: got %0d unemitted expected 0", exp_q.size()); end
        checks++; if (retire_cnt !== exp_retire) begin errors++; $display("FAIL inv_retire: got %0d expected %0d", retire_cnt, exp_retire); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        bus.trace_hold = 1'b1;
        push_exp(32'h0000_0013, 64'h8000_0504, 1'b0, 1'b0, 1'b0);
        tick();
        push_exp(32'h0010_0073, 64'h8000_0508, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (bus.wb_stall !== 1'b1) begin errors++; $display("FAIL rstdrain_in_drain: got stall %b expected 1", bus.wb_stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.trace_hold = 1'b0;
        exp_q.delete();
        en_hist = '0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (en_hist[3:0] !== 4'b0000) begin errors++; $display("FAIL rstdrain_out_en: got %b expected 0000", en_hist[3:0]); end
        checks++; if ({bus.wb_stall, halt, halt_invalid, retire_cnt} !== 67'd0) begin errors++; $display("FAIL rstdrain_state: got stall=%b halt=%b hinv=%b retire=%0d expected all 0", bus.wb_stall, halt, halt_invalid, retire_cnt); end
        obs_q.delete();
    endtask

    task automatic test_watchdog();
        do_reset();
`ifdef COMMIT_WATCHDOG_EN
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                checks++; if (wdog_expired !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b expected 0", wdog_expired); end
            end
        end
        checks++; if (wdog_expired !== 1'b1) begin errors++; $display("FAIL wdog_expire: got %b expected 1", wdog_expired); end
        tick();
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL wdog_halt_early: got %b expected 0", halt); end
        tick();
        checks++; if ({halt, halt_invalid} !== 2'b10) begin errors++; $display("FAIL wdog_halt: got %b expected 10", {halt, halt_invalid}); end
        // Retiring push restarts the count.
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        push_exp(32'h0000_0013, 64'h8000_0600, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        checks++; if (wdog_expired !== 1'b0) begin errors++; $display("FAIL wdog_clear: got %b expected 0", wdog_expired); end
        tick();
        checks++; if (wdog_expired !== 1'b1) begin errors++; $display("FAIL wdog_after_clear: got %b expected 1", wdog_expired); end
        // Reset while in DRAIN after a watchdog trip.
        do_reset();
        for (int i = 0; i < 16; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({wdog_expired, halt, halt_invalid, bus.wb_stall, bus.out_en, retire_cnt} !== 69'd0) begin errors++; $display("FAIL wdog_rst: got wdog=%b halt=%b hinv=%b stall=%b en=%b retire=%0d expected all 0", wdog_expired, halt, halt_invalid, bus.wb_stall, bus.out_en, retire_cnt); end
        tick();
        tick();
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL wdog_rst_halt: got %b expected 0", halt); end
`else
        for (int i = 0; i < 40; i++) tick();
        checks++; if ({wdog_expired, halt} !== 2'b00) begin errors++; $display("FAIL wdog_disabled: got %b expected 00", {wdog_expired, halt}); end
`endif
        obs_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_kill_ebreak();
        test_drain_ebreak();
        test_invalid();
        test_reset_mid_drain();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
